// File: rtl/fir_decimator.sv
// Decimating requantiser behind the FIR: keeps every DECIM-th sample, then shifts, saturates and queues it.
// Optional build macro FIR_DECIM_ROUND_EN selects round-half-up instead of truncation.
module fir_decimator #(
  parameter int IN_W       = 39,
  parameter int OUT_W      = 16,
  parameter int SHIFT      = 15,
  parameter int DECIM      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    sat_flag,
  output logic                    ovf_flag
);

  localparam int PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int EXT_W = IN_W + 1;

  localparam logic signed [EXT_W-1:0] MAX_V = EXT_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [EXT_W-1:0] MIN_V = -MAX_V - EXT_W'(1);

  logic [PH_W-1:0]         phase;
  logic                    keep;
  logic signed [EXT_W-1:0] ext;
  logic signed [EXT_W-1:0] pre;
  logic signed [EXT_W-1:0] s1_data;
  logic                    s1_valid;
  logic signed [OUT_W-1:0] s2_data;
  logic                    s2_valid;
  logic signed [OUT_W-1:0] sat_val;
  logic                    sat_hit;
  logic signed [OUT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [CNT_W-1:0]        count;
  logic                    full;
  logic                    pop;
  logic                    push;
  logic                    drop;

  assign keep = in_valid && (phase == '0);
  assign ext  = {in_data[IN_W-1], in_data};

`ifdef FIR_DECIM_ROUND_EN
  localparam logic signed [EXT_W-1:0] RND = EXT_W'(1) << (SHIFT - 1);
  assign pre = ext + RND;
`else
  assign pre = ext;
`endif

  always_comb begin
    sat_hit = 1'b0;
    sat_val = s1_data[OUT_W-1:0];
    if (s1_data > MAX_V) begin
      sat_hit = 1'b1;
      sat_val = MAX_V[OUT_W-1:0];
    end else if (s1_data < MIN_V) begin
      sat_hit = 1'b1;
      sat_val = MIN_V[OUT_W-1:0];
    end
  end

  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  // When full, a same-cycle pop frees the slot being written (wr_ptr == rd_ptr).
  assign push      = s2_valid && (!full || pop);
  assign drop      = s2_valid && full && !pop;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase    <= '0;
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
      sat_flag <= 1'b0;
      ovf_flag <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (clr) begin
      phase    <= '0;
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
      sat_flag <= 1'b0;
      ovf_flag <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (in_valid)
        phase <= (phase == PH_W'(DECIM - 1)) ? '0 : phase + PH_W'(1);
      s1_valid <= keep;
      if (keep)
        s1_data <= pre >>> SHIFT;
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= sat_val;
        if (sat_hit)
          sat_flag <= 1'b1;
      end
      if (drop)
        ovf_flag <= 1'b1;
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)
        count <= count + CNT_W'(1);
      else if (pop && !push)
        count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst && !clr && push)
      mem[wr_ptr] <= s2_data;
  end

endmodule

// File: doc/fir_decimator.md
Name: fir_decimator

Overview:
- Output stage directly downstream of the 74-tap FIR.
- Consumes the 39-bit signed accumulator result on each enabled sample cycle and decimates by DECIM.
- Requantises from Q15-scaled accumulator to 16-bit signed samples with saturation.
- Buffers results in a small FIFO behind a valid/ready interface so downstream stalls do not stall the FIR.

Parameters:
IN_W, 39, signed input width (FIR accumulator width)
OUT_W, 16, signed output sample width
SHIFT, 15, right-shift applied to input (tap Q-format fraction bits); must be >=1
DECIM, 4, decimation ratio; must be >=1
FIFO_DEPTH, 4, output FIFO entries; power of two, >=2

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
clr  in  1  synchronous clear: same effect as reset, applied on clk edge
in_valid  in  1  FIR output valid; the same strobe that enables the FIR shift register
in_data  in  IN_W  signed FIR accumulator output
out_valid  out  1  FIFO head valid
out_ready  in  1  downstream accepts head this cycle
out_data  out  OUT_W  signed requantised sample at FIFO head
sat_flag  out  1  sticky: at least one sample saturated
ovf_flag  out  1  sticky: at least one kept sample dropped because FIFO was full

Behaviour:
- Reset (rst=0, async) or clr=1 (sync) sets phase=0, both pipeline valids=0, FIFO empty, out_valid=0, out_data=0, sat_flag=0, ovf_flag=0. clr has priority over all other activity in that cycle.
- Phase counter, 0..DECIM-1:
  - Advances by 1 on every in_valid=1 cycle and wraps DECIM-1 -> 0.
  - A sample is kept only when in_valid=1 and phase==0, so kept samples are input indices 0, DECIM, 2*DECIM, ...
  - in_valid=0 cycles do not change phase.
- Stage 1 (registered, cycle N+1 for a sample kept in cycle N):
  - Sign-extend to IN_W+1.
  - Add round constant 2^(SHIFT-1) (see Optional Feature).
  - Arithmetic shift right by SHIFT.
- Stage 2 (registered, cycle N+2): saturate to OUT_W.
  - Value > 2^(OUT_W-1)-1 clamps to 32767.
  - Value < -2^(OUT_W-1) clamps to -32768.
  - Any clamp sets sat_flag in the cycle the stage-2 register loads.
- FIFO write:
  - Stage-2 valid writes at the end of cycle N+2.
  - With an empty FIFO, out_valid=1 and out_data is valid in cycle N+3. Total latency is 3 cycles.
- Handshake:
  - Pop occurs when out_valid && out_ready.
  - out_data is the registered FIFO head. It stays stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a pop (except on reset or clr).
  - out_ready while empty has no effect.
- Full FIFO:
  - The write succeeds if a pop occurs in the same cycle; count is unchanged and ordering is preserved.
  - Otherwise the stage-2 sample is discarded, ovf_flag is set, and FIFO contents are unchanged.
  - The pipeline never stalls, and the FIR is never back-pressured.
- Pointers wrap modulo FIFO_DEPTH. A separate count distinguishes full from empty.
- Flags clear only on reset or clr.
- Reset mid-operation discards the in-flight pipeline and FIFO contents. The first kept sample after reset is the first in_valid=1 sample.

Optional Feature:
- Macro FIR_DECIM_ROUND_EN.
- Defined: round-half-up, adding 2^(SHIFT-1) before the shift.
- Undefined: plain truncation toward minus infinity (shift only), removing the adder.
- Saturation, latency and all other behaviour are identical in both builds.

Test Plan:
- Reset: assert rst=0 mid-stream with FIFO holding 3 entries -> out_valid=0, out_data=0, sat_flag=0, ovf_flag=0 immediately. After release, the first in_valid sample is kept.
- Requantisation, DECIM=1, single samples:
  - in_data=114688 -> out_data=4 with FIR_DECIM_ROUND_EN, 3 without.
  - in_data=-16384 -> 0 with, -1 without.
  - out_valid rises exactly 3 cycles after in_valid.
- Saturation:
  - in_data=2^31 -> 32767, sat_flag=1.
  - in_data=-2^31 -> -32768.
  - in_data=32767*32768 -> 32767 with sat_flag staying 0 (fresh reset).
- Decimation, DECIM=4: 8 consecutive in_valid samples k*32768, k=0..7 -> exactly two outputs, 0 then 4. Inserting in_valid=0 gaps gives identical results.
- Backpressure, DECIM=4, FIFO_DEPTH=4: out_ready=0, feed samples k*32768, k=0..19 -> FIFO holds 0,4,8,12; sample 16 is dropped and ovf_flag=1. Then out_ready=1 -> 0,4,8,12 popped in order, one per cycle, and out_valid=0 afterwards.
- Full plus simultaneous pop: FIFO full, out_ready=1 in the cycle a stage-2 sample arrives -> no drop, ovf_flag stays 0, new sample appears last in order.
